// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle for the sprite DMA engine: CPU register snoop, work-RAM read
// port, OAM port-1 write port and CPU stall/status.
`timescale 1ns/1ps
interface oam_dma_ctrl_if;
   logic        cpu_ce;
   logic [15:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  oam_start_addr;
   logic [7:0]  ram_dout;
   logic        ram_sel;
   logic [15:0] ram_addr;
   logic        ram_rd;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_din;
   logic        oam_wren;
   logic        cpu_stall;
   logic        busy;
   logic        done;

   modport slave (
      input  cpu_ce, cpu_addr, cpu_wr, cpu_dout, oam_start_addr, ram_dout,
      output ram_sel, ram_addr, ram_rd, oam_addr, oam_din, oam_wren,
             cpu_stall, busy, done
   );

   modport master (
      output cpu_ce, cpu_addr, cpu_wr, cpu_dout, oam_start_addr, ram_dout,
      input  ram_sel, ram_addr, ram_rd, oam_addr, oam_din, oam_wren,
             cpu_stall, busy, done
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine for $4014: stalls the CPU and copies one 256-byte RAM page
// into OAM, alternating get (read) and put (write) CPU cycles.
`timescale 1ns/1ps
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter int          RAM_LATENCY  = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   oam_dma_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_DONE
   } state_t;

   typedef struct packed {
      logic [7:0] page;
      logic [7:0] idx;
      logic [7:0] oam_ptr;
   } ctx_t;

   state_t                 state, state_nxt;
   ctx_t                   ctx, ctx_nxt;
   logic [7:0]             data_lat;
   logic                   parity;
   logic [RAM_LATENCY:0]   vld_pipe;
   logic                   trigger;
   logic                   rd_enter;
   logic                   in_busy;
   logic                   in_xfer;

   assign trigger = bus.cpu_ce & bus.cpu_wr & (bus.cpu_addr == DMA_REG_ADDR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         ctx      <= '0;
         data_lat <= 8'h00;
         parity   <= 1'b0;
         vld_pipe <= '0;
      end else begin
         state <= state_nxt;
         ctx   <= ctx_nxt;
         if (bus.cpu_ce)
            parity <= ~parity;
         // vld_pipe[k] is high k+1 clks after READ entry; the last tap marks
         // the first edge at which ram_dout reflects {page,idx}.
         vld_pipe[0] <= rd_enter;
         for (int i = 1; i <= RAM_LATENCY; i++)
            vld_pipe[i] <= vld_pipe[i-1];
         if (vld_pipe[RAM_LATENCY])
            data_lat <= bus.ram_dout;
      end
   end

   always_comb begin
      state_nxt = state;
      ctx_nxt   = ctx;
      case (state)
         // DONE already behaves as IDLE for a trigger, so a back-to-back
         // $4014 write on the DONE clk is not lost.
         S_IDLE, S_DONE: begin
            if (trigger) begin
               state_nxt       = S_HALT;
               ctx_nxt.page    = bus.cpu_dout;
               ctx_nxt.idx     = 8'h00;
               ctx_nxt.oam_ptr = bus.oam_start_addr;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_HALT: begin
            // Reads must land on get cycles: parity 1 now means 0 next.
            if (bus.cpu_ce)
               state_nxt = parity ? S_READ : S_ALIGN;
         end
         S_ALIGN: begin
            if (bus.cpu_ce)
               state_nxt = S_READ;
         end
         S_READ: begin
            if (bus.cpu_ce)
               state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (bus.cpu_ce) begin
               ctx_nxt.idx     = ctx.idx + 8'd1;
               ctx_nxt.oam_ptr = ctx.oam_ptr + 8'd1;
               state_nxt       = (ctx.idx == 8'hFF) ? S_DONE : S_READ;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign rd_enter = bus.cpu_ce & (state_nxt == S_READ) & (state != S_READ);

   assign in_busy = (state == S_HALT) | (state == S_ALIGN) |
                    (state == S_READ) | (state == S_WRITE);
   assign in_xfer = (state == S_READ) | (state == S_WRITE);

   assign bus.busy      = in_busy;
   assign bus.cpu_stall = in_busy;
   assign bus.done      = (state == S_DONE);
   assign bus.ram_sel   = in_xfer;
   assign bus.ram_rd    = (state == S_READ);
   assign bus.ram_addr  = in_xfer ? {ctx.page, ctx.idx} : 16'h0000;
   assign bus.oam_addr  = (state == S_WRITE) ? ctx.oam_ptr : 8'h00;
   assign bus.oam_din   = (state == S_WRITE) ? data_lat : 8'h00;
   assign bus.oam_wren  = (state == S_WRITE) & bus.cpu_ce;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: RAM/OAM models, table of transfer vectors,
// plus hand sequences for an ignored re-trigger and a mid-transfer reset.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

   logic clk;
   logic reset_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   oam_dma_ctrl_if bus();

   oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014), .RAM_LATENCY(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [7:0] ram [0:65535];
   logic [7:0] oam [0:255];

   // Synchronous RAM, one clk latency.
   always @(posedge clk) bus.ram_dout <= ram[bus.ram_addr];

   int  wren_cnt, done_cnt, stall_cnt, noce_cnt;
   bit  rd_seen, first_par, tb_par, clr;

   // Mid-cycle observer: inputs settle at posedge+2, DUT acts on next posedge.
   always @(negedge clk) begin
      if (clr) begin
         wren_cnt  <= 0;
         done_cnt  <= 0;
         stall_cnt <= 0;
         noce_cnt  <= 0;
         rd_seen   <= 1'b0;
         first_par <= 1'b0;
         for (int i = 0; i < 256; i++) oam[i] <= 8'hEE;
      end else begin
         if (bus.cpu_ce && bus.cpu_stall) stall_cnt <= stall_cnt + 1;
         if (bus.oam_wren) begin
            wren_cnt <= wren_cnt + 1;
            oam[bus.oam_addr] <= bus.oam_din;
            if (!bus.cpu_ce) noce_cnt <= noce_cnt + 1;
         end
         if (bus.done) done_cnt <= done_cnt + 1;
         if (bus.ram_rd && !rd_seen) begin
            rd_seen   <= 1'b1;
            first_par <= tb_par;
         end
      end
      if (!reset_n)        tb_par <= 1'b0;
      else if (bus.cpu_ce) tb_par <= ~tb_par;
   end

   int tests, failed;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int         ce_cnt;
   bit         gaps, wr_pend, wr_any, wr_par;
   logic [7:0] wr_data;

   // One clk of stimulus; cpu_ce every 4 clks, or 7 when a gap is inserted.
   // Off-ce clks carry a $4014 write and ce clks carry decoys, both of which
   // must be ignored.
   task automatic tick();
      @(posedge clk);
      #2;
      if (ce_cnt == 0) begin
         bus.cpu_ce = 1'b1;
         ce_cnt = (gaps && $urandom_range(0, 2) == 0) ? 6 : 3;
      end else begin
         bus.cpu_ce = 1'b0;
         ce_cnt--;
      end
      if (!bus.cpu_ce) begin
         bus.cpu_wr = 1'b1; bus.cpu_addr = 16'h4014; bus.cpu_dout = 8'h07;
      end else if (wr_pend && (wr_any || tb_par == wr_par)) begin
         bus.cpu_wr = 1'b1; bus.cpu_addr = 16'h4014; bus.cpu_dout = wr_data;
         wr_pend = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
         bus.cpu_wr = 1'b1; bus.cpu_addr = 16'h4015; bus.cpu_dout = 8'h07;
      end else begin
         bus.cpu_wr = 1'b0; bus.cpu_addr = 16'h4014; bus.cpu_dout = 8'h07;
      end
   endtask

   task automatic trig(input logic [7:0] d, input bit any, input bit p);
      wr_data = d; wr_any = any; wr_par = p; wr_pend = 1'b1;
      for (int t = 0; t < 40 && wr_pend; t++) tick();
      chk("trigger_issued", wr_pend, 0);
      wr_pend = 1'b0;
   endtask

   task automatic clear_mon();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic wait_done();
      for (int t = 0; t < 9000 && done_cnt == 0; t++) tick();
      for (int t = 0; t < 12; t++) tick();
   endtask

   task automatic check_xfer(input string tag, input logic [7:0] page,
                             input logic [7:0] start, input int exp_stall);
      int err;
      logic [7:0] a;
      err = 0;
      for (int i = 0; i < 256; i++) begin
         a = start + 8'(i);
         if (oam[a] !== ram[{page, 8'(i)}]) err++;
      end
      chk({tag, "_wren"},      wren_cnt, 256);
      chk({tag, "_done"},      done_cnt, 1);
      chk({tag, "_stall"},     stall_cnt, exp_stall);
      chk({tag, "_wren_noce"}, noce_cnt, 0);
      chk({tag, "_rd_seen"},   rd_seen, 1);
      chk({tag, "_rd_par"},    first_par, 0);
      chk({tag, "_oam_err"},   err, 0);
      chk({tag, "_idle"},      {bus.busy, bus.cpu_stall, bus.ram_sel}, 0);
   endtask

   typedef struct {
      logic [7:0] page;
      logic [7:0] start;
      bit         par;
      bit         gaps;
      int         exp_stall;
   } vec_t;

   vec_t vecs [5];

   initial begin
      // trigger parity 0 -> HALT exits on a get cycle (513); parity 1 -> ALIGN (514)
      vecs[0] = '{8'h02, 8'h00, 1'b0, 1'b0, 513};
      vecs[1] = '{8'h02, 8'h00, 1'b1, 1'b0, 514};
      vecs[2] = '{8'h02, 8'h00, 1'b0, 1'b1, 513};
      vecs[3] = '{8'h02, 8'h00, 1'b1, 1'b1, 514};
      vecs[4] = '{8'h03, 8'hF0, 1'b0, 1'b0, 513};

      tests = 0; failed = 0;
      ce_cnt = 0; gaps = 1'b0; wr_pend = 1'b0; wr_any = 1'b0; wr_par = 1'b0;
      wr_data = 8'h00; clr = 1'b0;
      bus.cpu_ce = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wr = 1'b0;
      bus.cpu_dout = 8'h00; bus.oam_start_addr = 8'h00;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         ram[16'h0200 + i] = 8'(i) ^ 8'h5A;
         ram[16'h0300 + i] = 8'(i);
         ram[16'h0700 + i] = 8'hC3;
      end

      reset_n = 1'b0;
      for (int t = 0; t < 4; t++) tick();
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_oam_bus",  {bus.oam_addr, bus.oam_din}, 0);
      chk("rst_flags",    {bus.ram_sel, bus.ram_rd, bus.oam_wren,
                           bus.cpu_stall, bus.busy, bus.done}, 0);
      reset_n = 1'b1;
      for (int t = 0; t < 8; t++) tick();
      chk("idle_ignores_decoys", bus.busy, 0);

      for (int k = 0; k < 5; k++) begin
         bus.oam_start_addr = vecs[k].start;
         gaps = vecs[k].gaps;
         clear_mon();
         trig(vecs[k].page, 1'b0, vecs[k].par);
         wait_done();
         check_xfer($sformatf("v%0d", k), vecs[k].page, vecs[k].start,
                    vecs[k].exp_stall);
      end
      gaps = 1'b0;

      chk("wrap_oam_f0", oam[8'hF0], 8'h00);
      chk("wrap_oam_ff", oam[8'hFF], 8'h0F);
      chk("wrap_oam_00", oam[8'h00], 8'h10);
      chk("wrap_oam_ef", oam[8'hEF], 8'hFF);

      // $4014 write during byte 40 must not relatch the page.
      bus.oam_start_addr = 8'h00;
      clear_mon();
      trig(8'h02, 1'b0, 1'b0);
      for (int t = 0; t < 4000 && wren_cnt < 40; t++) tick();
      chk("retrig_busy", bus.busy, 1);
      trig(8'h07, 1'b1, 1'b0);
      wait_done();
      check_xfer("retrig", 8'h02, 8'h00, 513);

      // Reset after 100 bytes, then a fresh transfer.
      clear_mon();
      trig(8'h02, 1'b0, 1'b0);
      for (int t = 0; t < 4000 && wren_cnt < 100; t++) tick();
      chk("mid_busy_before_rst", bus.busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_flags", {bus.cpu_stall, bus.busy, bus.ram_sel, bus.oam_wren}, 0);
      for (int t = 0; t < 10; t++) tick();
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_wren",    wren_cnt, 100);
      reset_n = 1'b1;
      for (int t = 0; t < 8; t++) tick();
      clear_mon();
      trig(8'h03, 1'b0, 1'b0);
      wait_done();
      check_xfer("post_rst", 8'h03, 8'h00, 513);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
